// File: rtl/bank_pkg.sv
// Shared constants, batch payload type and FSM state encoding for the bank
// write scheduler and its helpers.
package bank_pkg;

   localparam int unsigned CHANNEL_NUMBER    = 3;
   localparam int unsigned CHANNEL_BANDWIDTH = 128;
   localparam int unsigned BLOCK_DEPTH       = 480;

   // Address width for a given depth; never below one bit.
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned ADDR_W = addr_w(BLOCK_DEPTH);

   // One batch: a lane per bank.
   typedef logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] batch_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_WAIT_BUF = 2'd2
   } state_t;

endpackage

// File: rtl/pingpong_owner_tracker.sv
// Ping-pong half ownership: tracks which half is being written, which half the
// reader owns, and which halves hold a completed, unreleased frame.
//   clk, rst_n   clock, asynchronous active-low reset
//   set_pulse    writer completed half write_sel: mark busy, move writer on
//   rel_pulse    reader done with half read_sel: clear busy, move reader on
//   busy         per-half frame-pending flags
//   write_sel    half currently being written
//   read_sel     half currently owned by the reader
module pingpong_owner_tracker
   import bank_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_pulse,
   input  logic       rel_pulse,
   output logic [1:0] busy,
   output logic       write_sel,
   output logic       read_sel
);

   logic       rel_ok;
   logic [1:0] busy_d;

   // A release of an idle half is ignored; set and release may coincide.
   always_comb begin
      rel_ok = rel_pulse && busy[read_sel];
      busy_d = busy;
      if (rel_ok)    busy_d[read_sel]  = 1'b0;
      if (set_pulse) busy_d[write_sel] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 2'b00;
         write_sel <= 1'b0;
         read_sel  <= 1'b0;
      end else begin
         busy <= busy_d;
         if (rel_ok)    read_sel  <= ~read_sel;
         if (set_pulse) write_sel <= ~write_sel;
      end
   end

endmodule

// File: rtl/bank_write_scheduler.sv
// Sequences batch writes from the input packer into the ping-pong bank buffers:
// per-frame batch address, registered write strobe, half select, frame hand-off
// to the matrix reader, and drop tracking when no half is free.
//   I_clk, I_rst_n     clock, asynchronous active-low reset
//   I_frame_start      start-of-frame pulse
//   I_valid, I_data    incoming batch (source cannot stall)
//   I_release          reader finished with half O_read_sel
//   O_data, O_address  registered batch and its address, valid with O_write_clk
//   O_write_clk        one-cycle write strobe
//   O_write_sel        half being written
//   O_read_sel         half owned by the reader
//   O_frame_ready      frame complete in half ~O_write_sel
//   O_ready            high while in WRITE
//   O_drop             sticky: a valid batch was discarded
// Optional: BANK_WRITE_STATS_EN adds O_frame_count and O_drop_count.
module bank_write_scheduler
   import bank_pkg::*;
(
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_frame_start,
   input  logic              I_valid,
   input  batch_t            I_data,
   input  logic              I_release,
   output batch_t            O_data,
   output logic [ADDR_W-1:0] O_address,
   output logic              O_write_clk,
   output logic              O_write_sel,
   output logic              O_read_sel,
   output logic              O_frame_ready,
   output logic              O_ready,
`ifdef BANK_WRITE_STATS_EN
   output logic [15:0]       O_frame_count,
   output logic [15:0]       O_drop_count,
`endif
   output logic              O_drop
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        busy;
   logic              busy_w;
   logic              start_ok;
   logic              wr_en;
   logic              last;
   logic              drop;

   pingpong_owner_tracker u_owner (
      .clk       (I_clk),
      .rst_n     (I_rst_n),
      .set_pulse (last),
      .rel_pulse (I_release),
      .busy      (busy),
      .write_sel (O_write_sel),
      .read_sel  (O_read_sel)
   );

   // Next state, accept/drop decision and address update.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      busy_w   = busy[O_write_sel];
      // Frame start is honoured in IDLE (free half) and in WRITE (short-frame restart).
      start_ok = I_frame_start &&
                 (((state_q == ST_IDLE) && !busy_w) || (state_q == ST_WRITE));
      wr_addr  = start_ok ? '0 : addr_q;
      wr_en    = I_valid && (start_ok || (state_q == ST_WRITE));
      // Explicit compare bounds the address for non-power-of-2 depths.
      last     = wr_en && (wr_addr == ADDR_W'(BLOCK_DEPTH - 1));
      drop     = I_valid && !wr_en;

      case (state_q)
         ST_IDLE: begin
            if (I_frame_start) state_d = busy_w ? ST_WAIT_BUF : ST_WRITE;
         end
         ST_WRITE:    state_d = ST_WRITE;
         ST_WAIT_BUF: begin
            if (!busy_w) state_d = ST_IDLE;
         end
         default:     state_d = ST_IDLE;
      endcase
      if (last) state_d = ST_IDLE;

      if (wr_en)         addr_d = last ? '0 : wr_addr + ADDR_W'(1);
      else if (start_ok) addr_d = '0;
   end

   // State and address registers.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Registered outputs toward the distributor and reader.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         O_data        <= '0;
         O_address     <= '0;
         O_write_clk   <= 1'b0;
         O_frame_ready <= 1'b0;
         O_ready       <= 1'b0;
         O_drop        <= 1'b0;
      end else begin
         if (wr_en) begin
            O_data    <= I_data;
            O_address <= wr_addr;
         end
         O_write_clk   <= wr_en;
         O_frame_ready <= last;
         O_ready       <= (state_d == ST_WRITE);
         O_drop        <= O_drop | drop;
      end
   end

`ifdef BANK_WRITE_STATS_EN
   // Completed frames wrap; dropped batches saturate.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         O_frame_count <= 16'd0;
         O_drop_count  <= 16'd0;
      end else begin
         if (last) O_frame_count <= O_frame_count + 16'd1;
         if (drop && (O_drop_count != 16'hFFFF)) O_drop_count <= O_drop_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bank_write_scheduler.sv
// Directed bench for bank_write_scheduler: a vector table for the opening
// cycles of a frame, then hand-written full-frame, buffer-wait and reset sequences.
module tb_bank_write_scheduler;
   import bank_pkg::*;

   logic              I_clk;
   logic              I_rst_n;
   logic              I_frame_start;
   logic              I_valid;
   batch_t            I_data;
   logic              I_release;
   batch_t            O_data;
   logic [ADDR_W-1:0] O_address;
   logic              O_write_clk;
   logic              O_write_sel;
   logic              O_read_sel;
   logic              O_frame_ready;
   logic              O_ready;
   logic              O_drop;
`ifdef BANK_WRITE_STATS_EN
   logic [15:0]       O_frame_count;
   logic [15:0]       O_drop_count;
`endif

   bank_write_scheduler dut (
      .I_clk         (I_clk),
      .I_rst_n       (I_rst_n),
      .I_frame_start (I_frame_start),
      .I_valid       (I_valid),
      .I_data        (I_data),
      .I_release     (I_release),
      .O_data        (O_data),
      .O_address     (O_address),
      .O_write_clk   (O_write_clk),
      .O_write_sel   (O_write_sel),
      .O_read_sel    (O_read_sel),
      .O_frame_ready (O_frame_ready),
      .O_ready       (O_ready),
`ifdef BANK_WRITE_STATS_EN
      .O_frame_count (O_frame_count),
      .O_drop_count  (O_drop_count),
`endif
      .O_drop        (O_drop)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic              fs;
      logic              v;
      logic              rel;
      int unsigned       tag;
      logic              e_wclk;
      logic [ADDR_W-1:0] e_addr;
      logic              e_ready;
      logic              e_fr;
      logic              e_ws;
      logic              e_rs;
   } vec_t;

   vec_t vt[7];

   function automatic batch_t mk(input int unsigned i);
      batch_t b;
      for (int k = 0; k < CHANNEL_NUMBER; k++) b[k] = {96'(k + 1), 32'(i)};
      return b;
   endfunction

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_addr(input string name, input logic [ADDR_W-1:0] act,
                           input logic [ADDR_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_data(input string name, input batch_t act, input batch_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

`ifdef BANK_WRITE_STATS_EN
   task automatic chk_cnt(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
`endif

   // One clock: drive inputs, clock edge, then sample 1 time unit later.
   task automatic step(input logic fs, input logic v, input logic rel, input batch_t d);
      I_frame_start = fs;
      I_valid       = v;
      I_release     = rel;
      I_data        = d;
      @(posedge I_clk);
      #1;
      I_frame_start = 1'b0;
      I_valid       = 1'b0;
      I_release     = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk_bit({name, " write_clk"}, O_write_clk, 1'b0);
      chk_addr({name, " address"}, O_address, '0);
      chk_data({name, " data"}, O_data, '0);
      chk_bit({name, " write_sel"}, O_write_sel, 1'b0);
      chk_bit({name, " read_sel"}, O_read_sel, 1'b0);
      chk_bit({name, " frame_ready"}, O_frame_ready, 1'b0);
      chk_bit({name, " ready"}, O_ready, 1'b0);
      chk_bit({name, " drop"}, O_drop, 1'b0);
`ifdef BANK_WRITE_STATS_EN
      chk_cnt({name, " frame_count"}, O_frame_count, 16'd0);
      chk_cnt({name, " drop_count"}, O_drop_count, 16'd0);
`endif
   endtask

   // n consecutive valid batches at addresses 0..n-1 in half ws0; frame start on the first if fs_first.
   task automatic run_frame(input string name, input logic fs_first, input logic ws0,
                            input int unsigned n, input int unsigned tagbase);
      logic is_last;
      for (int unsigned i = 0; i < n; i++) begin
         step(fs_first && (i == 0), 1'b1, 1'b0, mk(tagbase + i));
         is_last = (i == BLOCK_DEPTH - 1);
         chk_bit({name, " write_clk"}, O_write_clk, 1'b1);
         chk_addr({name, " address"}, O_address, ADDR_W'(i));
         chk_data({name, " data"}, O_data, mk(tagbase + i));
         chk_bit({name, " frame_ready"}, O_frame_ready, is_last);
         chk_bit({name, " write_sel"}, O_write_sel, is_last ? ~ws0 : ws0);
      end
   endtask

   initial begin
      // inputs, expected outputs after the edge
      vt[0] = '{1'b1, 1'b1, 1'b0, 10, 1'b1, ADDR_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 1'b1, 1'b0, 11, 1'b1, ADDR_W'(1), 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b0, 1'b1,  0, 1'b0, ADDR_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b1, 1'b0, 12, 1'b1, ADDR_W'(2), 1'b1, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b1, 1'b0, 1'b0,  0, 1'b0, ADDR_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 1'b0, 13, 1'b1, ADDR_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
      vt[6] = '{1'b0, 1'b1, 1'b0, 14, 1'b1, ADDR_W'(1), 1'b1, 1'b0, 1'b0, 1'b0};

      I_rst_n       = 1'b0;
      I_frame_start = 1'b0;
      I_valid       = 1'b0;
      I_release     = 1'b0;
      I_data        = '0;
      repeat (2) @(posedge I_clk);
      #1;
      chk_all_zero("reset");
      I_rst_n = 1'b1;

      // Same-cycle start+valid, gaps, idle-half release ignored, short-frame restart.
      for (int r = 0; r < 7; r++) begin
         step(vt[r].fs, vt[r].v, vt[r].rel, mk(vt[r].tag));
         chk_bit($sformatf("vec%0d write_clk", r), O_write_clk, vt[r].e_wclk);
         if (vt[r].e_wclk) begin
            chk_addr($sformatf("vec%0d address", r), O_address, vt[r].e_addr);
            chk_data($sformatf("vec%0d data", r), O_data, mk(vt[r].tag));
         end
         chk_bit($sformatf("vec%0d ready", r), O_ready, vt[r].e_ready);
         chk_bit($sformatf("vec%0d frame_ready", r), O_frame_ready, vt[r].e_fr);
         chk_bit($sformatf("vec%0d write_sel", r), O_write_sel, vt[r].e_ws);
         chk_bit($sformatf("vec%0d read_sel", r), O_read_sel, vt[r].e_rs);
      end

      // Short frame of 100 batches, then a restart: next strobe at 0, same half.
      step(1'b1, 1'b0, 1'b0, '0);
      run_frame("short", 1'b0, 1'b0, 100, 1000);
      step(1'b1, 1'b0, 1'b0, '0);
      chk_bit("restart write_clk", O_write_clk, 1'b0);
      chk_bit("restart ready", O_ready, 1'b1);

      // Full frame into half 0; completion pulse on the address 479 strobe.
      run_frame("frame1", 1'b0, 1'b0, BLOCK_DEPTH, 2000);
      chk_bit("frame1 ready after last", O_ready, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0);
      chk_bit("frame1 idle write_clk", O_write_clk, 1'b0);
      chk_bit("frame1 idle frame_ready", O_frame_ready, 1'b0);
      chk_bit("frame1 idle drop", O_drop, 1'b0);

      // Second full frame into half 1 with no release: both halves pending.
      run_frame("frame2", 1'b1, 1'b1, BLOCK_DEPTH, 3000);

      // Third frame: no free half -> WAIT_BUF, batches dropped.
      step(1'b1, 1'b1, 1'b0, mk(9));
      chk_bit("wait write_clk", O_write_clk, 1'b0);
      chk_bit("wait ready", O_ready, 1'b0);
      chk_bit("wait drop", O_drop, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, mk(20 + i));
         chk_bit("wait drop write_clk", O_write_clk, 1'b0);
         chk_bit("wait drop sticky", O_drop, 1'b1);
      end
`ifdef BANK_WRITE_STATS_EN
      chk_cnt("stats frame_count", O_frame_count, 16'd2);
      chk_cnt("stats drop_count", O_drop_count, 16'd5);
`endif

      // Reader releases half 0; scheduler returns to IDLE and refills half 0.
      step(1'b0, 1'b0, 1'b1, '0);
      chk_bit("release read_sel", O_read_sel, 1'b1);
      chk_bit("release ready", O_ready, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0);
      chk_bit("post-release ready", O_ready, 1'b0);
      run_frame("frame4", 1'b1, 1'b0, 251, 4000);
      chk_bit("frame4 ready", O_ready, 1'b1);
      chk_bit("frame4 drop sticky", O_drop, 1'b1);

      // Asynchronous reset mid-frame at address 250: outputs clear without a clock edge.
      #1;
      I_rst_n = 1'b0;
      #1;
      chk_all_zero("async reset");
      @(posedge I_clk);
      #1;
      I_rst_n = 1'b1;
      run_frame("after reset", 1'b1, 1'b0, 3, 5000);
      chk_bit("after reset drop", O_drop, 1'b0);
      chk_bit("after reset read_sel", O_read_sel, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
